// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage: dmem FSM state encoding,
// bubble constants and default widths.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DONE     = 2'd2
  } dmem_state_t;

  // Value loaded into every EX/MEM control bit when a bubble is inserted.
  localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/mem_stage_dmem_fsm.sv
// Data-memory handshake controller: owns the request/response state, the load
// buffer and the pipeline-wide stall raised while a memory op is in flight.
module mem_stage_dmem_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_op,
  input  logic              is_load,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rdata,
  output logic              req_valid,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_buf
);

  dmem_state_t       state_reg;
  logic [DATA_W-1:0] load_buf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      load_buf_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_op && req_ready) state_reg <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          // Responses are only looked at here; strays in IDLE/DONE fall on the floor.
          if (rsp_valid) begin
            if (is_load) load_buf_reg <= rdata;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Decoded purely from registered state and the registered EX/MEM op.
  assign req_valid = (state_reg == ST_IDLE) && mem_op;
  assign mem_stall = req_valid || (state_reg == ST_WAIT_RSP);
  assign load_buf  = load_buf_reg;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, branch redirect and dmem access.
// Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned accesses and flags them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] EX_ALU_result,
  input  logic              EX_zero,
  input  logic [REG_W-1:0]  EX_rd,
  input  logic              EX_stall,
  input  logic              EX_branch,
  input  logic              EX_memread,
  input  logic              EX_memtoreg,
  input  logic              EX_memwrite,
  input  logic              EX_regwrite,
  input  logic              EX_unconditional_jmp,
  input  logic [DATA_W-1:0] EX_rs2_data,
  output logic [DATA_W-1:0] EX_MEM_ALU_result,
  output logic [REG_W-1:0]  EX_MEM_rd,
  output logic              EX_MEM_regwrite,
  output logic              EX_MEM_memtoreg,
  output logic              EX_MEM_memread,
  output logic              MEM_pc_src,
  output logic              MEM_stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              MEM_misalign_err,
`endif
  output logic [REG_W-1:0]  MEM_WB_rd,
  output logic              MEM_WB_regwrite,
  output logic [DATA_W-1:0] MEM_WB_result
);

  logic              ex_mem_branch_reg;
  logic              ex_mem_zero_reg;
  logic              ex_mem_memwrite_reg;
  logic              ex_mem_jmp_reg;
  logic [DATA_W-1:0] ex_mem_rs2_reg;
  logic              mem_op;
  logic              misalign;
  logic [DATA_W-1:0] load_buf;

  // A held EX/MEM slot wins over the load-use bubble so the stalled op survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_ALU_result   <= '0;
      EX_MEM_rd           <= '0;
      EX_MEM_regwrite     <= 1'b0;
      EX_MEM_memtoreg     <= 1'b0;
      EX_MEM_memread      <= 1'b0;
      ex_mem_branch_reg   <= 1'b0;
      ex_mem_zero_reg     <= 1'b0;
      ex_mem_memwrite_reg <= 1'b0;
      ex_mem_jmp_reg      <= 1'b0;
      ex_mem_rs2_reg      <= '0;
    end else if (!MEM_stall) begin
      if (EX_stall) begin
        EX_MEM_ALU_result   <= '0;
        EX_MEM_rd           <= '0;
        EX_MEM_regwrite     <= BUBBLE_CTRL;
        EX_MEM_memtoreg     <= BUBBLE_CTRL;
        EX_MEM_memread      <= BUBBLE_CTRL;
        ex_mem_branch_reg   <= BUBBLE_CTRL;
        ex_mem_zero_reg     <= BUBBLE_CTRL;
        ex_mem_memwrite_reg <= BUBBLE_CTRL;
        ex_mem_jmp_reg      <= BUBBLE_CTRL;
        ex_mem_rs2_reg      <= '0;
      end else begin
        EX_MEM_ALU_result   <= EX_ALU_result;
        EX_MEM_rd           <= EX_rd;
        EX_MEM_regwrite     <= EX_regwrite;
        EX_MEM_memtoreg     <= EX_memtoreg;
        EX_MEM_memread      <= EX_memread;
        ex_mem_branch_reg   <= EX_branch;
        ex_mem_zero_reg     <= EX_zero;
        ex_mem_memwrite_reg <= EX_memwrite;
        ex_mem_jmp_reg      <= EX_unconditional_jmp;
        ex_mem_rs2_reg      <= EX_rs2_data;
      end
    end
  end

  assign mem_op = EX_MEM_memread | ex_mem_memwrite_reg;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op & (|EX_MEM_ALU_result[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MEM_misalign_err <= 1'b0;
    else if (misalign && !MEM_stall) MEM_misalign_err <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  mem_stage_dmem_fsm #(.DATA_W(DATA_W)) u_dmem_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_op    (mem_op & ~misalign),
    .is_load   (EX_MEM_memread),
    .req_ready (dmem_req_ready),
    .rsp_valid (dmem_rsp_valid),
    .rdata     (dmem_rdata),
    .req_valid (dmem_req_valid),
    .mem_stall (MEM_stall),
    .load_buf  (load_buf)
  );

  assign dmem_addr  = EX_MEM_ALU_result[ADDR_W-1:0];
  assign dmem_we    = ex_mem_memwrite_reg;
  assign dmem_wdata = ex_mem_rs2_reg;
  assign MEM_pc_src = ex_mem_jmp_reg | (ex_mem_branch_reg & ex_mem_zero_reg);

  // MEM/WB holds during a stall; rewriting the same value is harmless downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_rd       <= '0;
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_result   <= '0;
    end else if (!MEM_stall) begin
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_regwrite <= EX_MEM_regwrite & ~misalign;
      MEM_WB_result   <= EX_MEM_memtoreg ? load_buf : EX_MEM_ALU_result;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Downstream neighbour of the execute stage. Holds the EX/MEM pipeline register and runs the data-memory handshake for loads and stores.
- Produces the MEM/WB pipeline register and the EX_MEM_*/MEM_WB_* forwarding signals that the EX hazard checker consumes.
- Resolves the branch/jump redirect from registered EX results.
- Stalls the whole pipeline while a memory transaction is outstanding.

Parameters:
DATA_W, 32, width of ALU result, store data and load data
ADDR_W, 32, data-memory address width; low ADDR_W bits of ALU result
REG_W, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
EX_ALU_result  input  DATA_W  ALU result / memory address
EX_zero  input  1  ALU zero flag
EX_rd  input  REG_W  destination register
EX_stall  input  1  load-use stall from hazard checker; EX contents invalid this cycle
EX_branch, EX_memread, EX_memtoreg, EX_memwrite, EX_regwrite, EX_unconditional_jmp  input  1 each  control bits
EX_rs2_data  input  DATA_W  forwarded store data
EX_MEM_ALU_result  output  DATA_W  registered ALU result
EX_MEM_rd  output  REG_W  registered rd
EX_MEM_regwrite, EX_MEM_memtoreg, EX_MEM_memread  output  1 each  registered controls
MEM_pc_src  output  1  redirect fetch
MEM_stall  output  1  freeze IF/ID/ID_EX/EX_MEM
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  request accepted
dmem_we  output  1  1=store
dmem_addr  output  ADDR_W  word address
dmem_wdata  output  DATA_W  store data
dmem_rsp_valid  input  1  response (load data or store ack)
dmem_rdata  input  DATA_W  load data
MEM_WB_rd  output  REG_W  registered rd
MEM_WB_regwrite  output  1  registered write enable
MEM_WB_result  output  DATA_W  writeback value

Behaviour:
- Reset (async, rst_n=0): all EX_MEM_* and MEM_WB_* registers 0; FSM IDLE; load buffer 0; dmem_req_valid=0, MEM_stall=0, MEM_pc_src=0.
- EX_MEM register update on clk, when MEM_stall=0:
  - EX_stall=1: load a bubble (all control bits 0, rd 0, data 0).
  - Otherwise: capture the EX_* inputs.
  - MEM_stall=1: hold the register. MEM_stall has priority over EX_stall.
- mem_op = EX_MEM_memread | EX_MEM_memwrite.
- FSM states: IDLE, WAIT_RSP, DONE.
  - IDLE, no mem_op: MEM_stall=0; instruction passes in one cycle.
  - IDLE, mem_op: dmem_req_valid=1, MEM_stall=1. On dmem_req_ready -> WAIT_RSP; otherwise remain in IDLE with the request held stable.
  - WAIT_RSP: MEM_stall=1, dmem_req_valid=0. On dmem_rsp_valid capture dmem_rdata into the load buffer (loads only) -> DONE.
  - DONE: MEM_stall=0; next edge -> IDLE while EX_MEM advances.
- Response timing:
  - dmem_rsp_valid is never sampled in IDLE or DONE; a stray or late response there is ignored.
  - A response in the same cycle as ready is not permitted; the response arrives at least 1 cycle after acceptance.
- Minimum memory-op occupancy: 3 cycles (ready immediately, response next cycle).
- dmem_addr = EX_MEM_ALU_result[ADDR_W-1:0]; dmem_we = EX_MEM_memwrite; dmem_wdata = registered EX_rs2_data. All stable while dmem_req_valid=1.
- MEM_WB register update on clk, when MEM_stall=0:
  - MEM_WB_rd <= EX_MEM_rd; MEM_WB_regwrite <= EX_MEM_regwrite.
  - MEM_WB_result <= (EX_MEM_memtoreg ? load buffer : EX_MEM_ALU_result).
  - MEM_stall=1: MEM_WB holds its value; the regfile rewrite is idempotent and forwarding stays valid.
- MEM_pc_src = EX_MEM_unconditional_jmp | (EX_MEM_branch & EX_MEM_zero). Combinational from EX_MEM; bubbles give 0.
- Reset mid-transaction: the request is abandoned immediately and the FSM returns to IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - A mem_op with EX_MEM_ALU_result[1:0]!=0 issues no request and stays in IDLE with MEM_stall=0.
  - Its regwrite is forced to 0 into MEM_WB.
  - Extra output MEM_misalign_err (1 bit) is set sticky on that edge; cleared only by reset.
- Undefined: the port is absent and misaligned addresses are passed to dmem unchanged.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT_RSP=2'd1, DONE=2'd2), bubble/reset constants, DATA_W/REG_W defaults.
- One sub-module is natural: mem_stage_dmem_fsm. It owns the state register, load buffer, dmem_req_* drive and MEM_stall.
- Pipeline registers and MEM_pc_src stay in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_RSP -> req_valid=0, MEM_stall=0, all MEM_WB_* 0; a late rsp_valid after release is ignored.
- ALU op: EX_ALU_result=32'h15, rd=7, regwrite=1 -> after 2 edges MEM_WB_result=32'h15, rd=7, regwrite=1; MEM_stall never 1.
- Load: ALU_result=32'h100, memread=memtoreg=1, rd=3; ready held 0 for 2 cycles, rsp one cycle after ready with rdata=32'hDEADBEEF -> dmem_addr=32'h100 stable; MEM_stall high 4 cycles; MEM_WB_result=32'hDEADBEEF, rd=3.
- Store: memwrite=1, ALU_result=32'h40, rs2=32'hA5A5 -> dmem_we=1, wdata=32'hA5A5; MEM_WB_regwrite=0; stall ends the cycle after the ack.
- Branch/stall: EX_branch=1, EX_zero=1 -> MEM_pc_src=1 one cycle later; EX_stall=1 -> EX_MEM bubble and MEM_pc_src=0.
- EX_stall during MEM_stall: EX_MEM holds the load and no bubble is inserted; MEM_WB keeps the prior value with regwrite unchanged.
